// File: rtl/reorder_buffer_pkg.sv
// Shared widths, tag encoding and entry layout for the reorder buffer.
// Tags are index+1 so that tag 0 can mean "no producer".
package reorder_buffer_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int REG_TAG_WIDTH = 5;
  localparam int ROB_TAG_WIDTH = 5;
  localparam int DEPTH         = 16;
  localparam int ROB_IDX_WIDTH = ROB_TAG_WIDTH - 1;

  typedef logic [ROB_TAG_WIDTH-1:0] rob_tag_t;
  typedef logic [ROB_IDX_WIDTH-1:0] rob_idx_t;
  typedef logic [REG_TAG_WIDTH-1:0] reg_tag_t;
  typedef logic [DATA_WIDTH-1:0]    data_t;

  localparam rob_tag_t ZERO_TAG_ROB = '0;
  localparam data_t    ZERO_DATA    = '0;
  localparam logic     TRUE         = 1'b1;
  localparam logic     FALSE        = 1'b0;

  // Payload of one entry; busy/ready live in separate bit vectors.
  typedef struct packed {
    reg_tag_t dest;
    logic     is_branch;
    logic     pred_taken;
    logic     taken;
    data_t    value;
    data_t    target;
  } rob_data_t;

  function automatic rob_tag_t idx_to_tag(rob_idx_t idx);
    return rob_tag_t'({1'b0, idx}) + rob_tag_t'(1);
  endfunction

  function automatic rob_idx_t tag_to_idx(rob_tag_t tag);
    return rob_idx_t'(tag - rob_tag_t'(1));
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch, CDB, operand-query and commit signals of the reorder buffer.
// master = surrounding core, slave = reorder buffer.
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  logic     rdy;
  logic     in_fetcher_ce;
  reg_tag_t in_alloc_dest_reg;
  logic     in_alloc_is_branch;
  logic     in_alloc_pred_taken;
  rob_tag_t out_alloc_tag;
  logic     out_full;

  logic     in_alu_valid;
  rob_tag_t in_alu_tag;
  data_t    in_alu_value;
  logic     in_alu_taken;
  data_t    in_alu_target;
  logic     in_lsb_valid;
  rob_tag_t in_lsb_tag;
  data_t    in_lsb_value;

  rob_tag_t in_query_tag1;
  rob_tag_t in_query_tag2;
  logic     out_query_ready1;
  logic     out_query_ready2;
  data_t    out_query_value1;
  data_t    out_query_value2;

  reg_tag_t out_commit_reg;
  rob_tag_t out_commit_rob;
  data_t    out_commit_value;
  logic     out_misbranch;
  data_t    out_misbranch_pc;

  modport master (
    output rdy, in_fetcher_ce, in_alloc_dest_reg, in_alloc_is_branch, in_alloc_pred_taken,
    output in_alu_valid, in_alu_tag, in_alu_value, in_alu_taken, in_alu_target,
    output in_lsb_valid, in_lsb_tag, in_lsb_value, in_query_tag1, in_query_tag2,
    input  out_alloc_tag, out_full, out_query_ready1, out_query_ready2,
    input  out_query_value1, out_query_value2, out_commit_reg, out_commit_rob,
    input  out_commit_value, out_misbranch, out_misbranch_pc
  );

  modport slave (
    input  rdy, in_fetcher_ce, in_alloc_dest_reg, in_alloc_is_branch, in_alloc_pred_taken,
    input  in_alu_valid, in_alu_tag, in_alu_value, in_alu_taken, in_alu_target,
    input  in_lsb_valid, in_lsb_tag, in_lsb_value, in_query_tag1, in_query_tag2,
    output out_alloc_tag, out_full, out_query_ready1, out_query_ready2,
    output out_query_value1, out_query_value2, out_commit_reg, out_commit_rob,
    output out_commit_value, out_misbranch, out_misbranch_pc
  );

endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates per issued instruction, captures CDB
// results, retires one entry per cycle and flushes on a head misprediction.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  reorder_buffer_if.slave  bus
);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DEPTH-1:0] ready_q, ready_d;
  rob_data_t        data_q [DEPTH];
  rob_idx_t         head_q, tail_q;
  rob_tag_t         count_q, count_d;

  reg_tag_t commit_reg_q;
  rob_tag_t commit_rob_q;
  data_t    commit_val_q;
  logic     mis_q, mis_pend_q;
  data_t    mis_pc_q, mis_tgt_q;

  logic             full, accept, alloc_fire, commit_fire, head_mispred;
  logic [DEPTH-1:0] alu_hit, lsb_hit;
  logic [DATA_WIDTH:0] look1, look2;

  assign full   = (count_q == rob_tag_t'(DEPTH));
  // Inputs arriving during the flush pulse belong to the wrong path.
  assign accept = bus.rdy && !mis_q;

  assign alloc_fire   = accept && !mis_pend_q && bus.in_fetcher_ce && !full;
  assign commit_fire  = accept && !mis_pend_q && busy_q[head_q] && ready_q[head_q];
  assign head_mispred = data_q[head_q].is_branch &&
                        (data_q[head_q].taken != data_q[head_q].pred_taken);

  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    assign alu_hit[i] = accept && bus.in_alu_valid && busy_q[i] &&
                        (bus.in_alu_tag == idx_to_tag(rob_idx_t'(i)));
    assign lsb_hit[i] = accept && bus.in_lsb_valid && busy_q[i] &&
                        (bus.in_lsb_tag == idx_to_tag(rob_idx_t'(i)));
  end

  // Operand lookup: {ready, value}, with CDB forwarding for this cycle.
  function automatic logic [DATA_WIDTH:0] lookup(
    input rob_tag_t tag,
    input logic     fwd_en,
    input logic     alu_v,
    input rob_tag_t alu_t,
    input data_t    alu_val,
    input logic     lsb_v,
    input rob_tag_t lsb_t,
    input data_t    lsb_val,
    input logic     ent_rdy,
    input data_t    ent_val
  );
    if (tag == ZERO_TAG_ROB)                return {TRUE, ZERO_DATA};
    if (fwd_en && alu_v && (alu_t == tag))  return {TRUE, alu_val};
    if (fwd_en && lsb_v && (lsb_t == tag))  return {TRUE, lsb_val};
    return {ent_rdy, ent_val};
  endfunction

  always_comb begin
    look1 = lookup(bus.in_query_tag1, accept, bus.in_alu_valid, bus.in_alu_tag,
                   bus.in_alu_value, bus.in_lsb_valid, bus.in_lsb_tag, bus.in_lsb_value,
                   ready_q[tag_to_idx(bus.in_query_tag1)],
                   data_q[tag_to_idx(bus.in_query_tag1)].value);
    look2 = lookup(bus.in_query_tag2, accept, bus.in_alu_valid, bus.in_alu_tag,
                   bus.in_alu_value, bus.in_lsb_valid, bus.in_lsb_tag, bus.in_lsb_value,
                   ready_q[tag_to_idx(bus.in_query_tag2)],
                   data_q[tag_to_idx(bus.in_query_tag2)].value);
  end

  always_comb begin
    busy_d  = busy_q;
    ready_d = ready_q | alu_hit | lsb_hit;
    if (alloc_fire) begin
      busy_d[tail_q]  = TRUE;
      ready_d[tail_q] = FALSE;
    end
    if (commit_fire) begin
      busy_d[head_q] = FALSE;
    end
    count_d = count_q;
    case ({alloc_fire, commit_fire})
      2'b10:   count_d = count_q + rob_tag_t'(1);
      2'b01:   count_d = count_q - rob_tag_t'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q       <= '0;
      ready_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      commit_reg_q <= '0;
      commit_rob_q <= ZERO_TAG_ROB;
      commit_val_q <= ZERO_DATA;
      mis_q        <= FALSE;
      mis_pend_q   <= FALSE;
      mis_pc_q     <= ZERO_DATA;
    end else if (!bus.rdy) begin
      commit_reg_q <= '0;
      commit_rob_q <= ZERO_TAG_ROB;
      commit_val_q <= ZERO_DATA;
      mis_q        <= FALSE;
    end else if (mis_pend_q) begin
      busy_q       <= '0;
      ready_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      commit_reg_q <= '0;
      commit_rob_q <= ZERO_TAG_ROB;
      commit_val_q <= ZERO_DATA;
      mis_q        <= TRUE;
      mis_pend_q   <= FALSE;
      mis_pc_q     <= mis_tgt_q;
    end else begin
      busy_q       <= busy_d;
      ready_q      <= ready_d;
      count_q      <= count_d;
      mis_q        <= FALSE;
      commit_reg_q <= '0;
      commit_rob_q <= ZERO_TAG_ROB;
      commit_val_q <= ZERO_DATA;
      if (alloc_fire) begin
        tail_q <= tail_q + rob_idx_t'(1);
      end
      if (commit_fire) begin
        commit_reg_q <= data_q[head_q].dest;
        commit_rob_q <= idx_to_tag(head_q);
        commit_val_q <= data_q[head_q].value;
        head_q       <= head_q + rob_idx_t'(1);
        mis_pend_q   <= head_mispred;
      end
    end
  end

  // Entry payload; validity is tracked entirely by busy/ready above.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (alu_hit[i]) begin
        data_q[i].value  <= bus.in_alu_value;
        data_q[i].taken  <= bus.in_alu_taken;
        data_q[i].target <= bus.in_alu_target;
      end else if (lsb_hit[i]) begin
        data_q[i].value  <= bus.in_lsb_value;
      end
    end
    if (alloc_fire) begin
      data_q[tail_q].dest       <= bus.in_alloc_dest_reg;
      data_q[tail_q].is_branch  <= bus.in_alloc_is_branch;
      data_q[tail_q].pred_taken <= bus.in_alloc_pred_taken;
      data_q[tail_q].taken      <= FALSE;
    end
    if (commit_fire && head_mispred) begin
      mis_tgt_q <= data_q[head_q].target;
    end
  end

  assign bus.out_alloc_tag    = idx_to_tag(tail_q);
  assign bus.out_full         = full;
  assign bus.out_query_ready1 = look1[DATA_WIDTH];
  assign bus.out_query_value1 = look1[DATA_WIDTH-1:0];
  assign bus.out_query_ready2 = look2[DATA_WIDTH];
  assign bus.out_query_value2 = look2[DATA_WIDTH-1:0];
  assign bus.out_commit_reg   = commit_reg_q;
  assign bus.out_commit_rob   = commit_rob_q;
  assign bus.out_commit_value = commit_val_q;
  assign bus.out_misbranch    = mis_q;
  assign bus.out_misbranch_pc = mis_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: expected commits and flush targets are
// queued as stimulus is driven and retired against the DUT outputs.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reorder_buffer_if rif();
  reorder_buffer dut (.clk(clk), .rst(rst), .bus(rif));

  typedef struct packed {
    reg_tag_t dest;
    rob_tag_t tag;
    data_t    value;
  } commit_t;

  commit_t sb_q[$];
  data_t   mis_exp_q[$];
  int      commit_cyc[$];
  int      n_checks = 0;
  int      n_fail   = 0;
  int      cyc      = 0;
  int      mis_seen = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Commit/flush monitor, sampled on the falling edge.
  always @(negedge clk) begin
    commit_t e;
    cyc++;
    if (!rst) begin
      if (rif.out_commit_rob != ZERO_TAG_ROB) begin
        commit_cyc.push_back(cyc);
        if (sb_q.size() == 0) begin
          chk("spurious_commit", rif.out_commit_rob, ZERO_TAG_ROB);
        end else begin
          e = sb_q.pop_front();
          chk("commit_reg",   rif.out_commit_reg,   e.dest);
          chk("commit_rob",   rif.out_commit_rob,   e.tag);
          chk("commit_value", rif.out_commit_value, e.value);
        end
      end else begin
        chk("idle_commit_reg", rif.out_commit_reg, 0);
      end
      if (rif.out_misbranch) begin
        mis_seen++;
        if (mis_exp_q.size() == 0) chk("spurious_misbranch", rif.out_misbranch, 0);
        else chk("misbranch_pc", rif.out_misbranch_pc, mis_exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    commit_cyc.delete();
    mis_seen = 0;
  endtask

  task automatic expect_commit(input int dest, input int tag, input int value);
    sb_q.push_back('{dest: reg_tag_t'(dest), tag: rob_tag_t'(tag), value: data_t'(value)});
  endtask

  task automatic alloc(input int dest, input logic br, input logic pred);
    rif.in_fetcher_ce       = 1'b1;
    rif.in_alloc_dest_reg   = reg_tag_t'(dest);
    rif.in_alloc_is_branch  = br;
    rif.in_alloc_pred_taken = pred;
    tick();
    rif.in_fetcher_ce       = 1'b0;
    rif.in_alloc_is_branch  = 1'b0;
    rif.in_alloc_pred_taken = 1'b0;
  endtask

  task automatic alu_wr(input int tag, input int value, input logic taken, input int target);
    rif.in_alu_valid  = 1'b1;
    rif.in_alu_tag    = rob_tag_t'(tag);
    rif.in_alu_value  = data_t'(value);
    rif.in_alu_taken  = taken;
    rif.in_alu_target = data_t'(target);
    tick();
    rif.in_alu_valid  = 1'b0;
  endtask

  task automatic lsb_wr(input int tag, input int value);
    rif.in_lsb_valid = 1'b1;
    rif.in_lsb_tag   = rob_tag_t'(tag);
    rif.in_lsb_value = data_t'(value);
    tick();
    rif.in_lsb_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rif.rdy = 1'b1;
    rif.in_fetcher_ce = 1'b0;
    rif.in_alloc_dest_reg = '0;
    rif.in_alloc_is_branch = 1'b0;
    rif.in_alloc_pred_taken = 1'b0;
    rif.in_alu_valid = 1'b0;
    rif.in_alu_tag = '0;
    rif.in_alu_value = '0;
    rif.in_alu_taken = 1'b0;
    rif.in_alu_target = '0;
    rif.in_lsb_valid = 1'b0;
    rif.in_lsb_tag = '0;
    rif.in_lsb_value = '0;
    rif.in_query_tag1 = '0;
    rif.in_query_tag2 = '0;

    // Reset state
    do_reset();
    chk("rst_full",       rif.out_full, 0);
    chk("rst_alloc_tag",  rif.out_alloc_tag, 1);
    chk("rst_commit_reg", rif.out_commit_reg, 0);
    chk("rst_commit_rob", rif.out_commit_rob, 0);
    chk("rst_commit_val", rif.out_commit_value, 0);
    chk("rst_misbranch",  rif.out_misbranch, 0);
    chk("rst_mis_pc",     rif.out_misbranch_pc, 0);

    // Out-of-order writeback, in-order retirement
    alloc(1, 1'b0, 1'b0);
    chk("t1_alloc_tag", rif.out_alloc_tag, 2);
    alloc(2, 1'b0, 1'b0);
    alu_wr(2, 7, 1'b0, 0);
    chk("t1_no_early_commit", rif.out_commit_rob, 0);
    expect_commit(1, 1, 5);
    expect_commit(2, 2, 7);
    alu_wr(1, 5, 1'b0, 0);
    chk("t1_same_edge", rif.out_commit_rob, 0);
    tick();
    chk("t1_first_commit", rif.out_commit_rob, 1);
    repeat (4) tick();
    chk("t1_commit_count", commit_cyc.size(), 2);
    if (commit_cyc.size() >= 2) chk("t1_consecutive", commit_cyc[1] - commit_cyc[0], 1);

    // Fill, overflow attempt, wrap
    do_reset();
    for (int i = 0; i < DEPTH; i++) alloc(i + 1, 1'b0, 1'b0);
    chk("t2_full", rif.out_full, 1);
    chk("t2_tag_wrap", rif.out_alloc_tag, 1);
    alloc(30, 1'b0, 1'b0);
    chk("t2_full_hold", rif.out_full, 1);
    chk("t2_tag_hold", rif.out_alloc_tag, 1);
    expect_commit(1, 1, 32'h1000);
    alu_wr(1, 32'h1000, 1'b0, 0);
    tick();
    chk("t2_not_full", rif.out_full, 0);
    chk("t2_next_tag", rif.out_alloc_tag, 1);
    alloc(20, 1'b0, 1'b0);
    chk("t2_refull", rif.out_full, 1);
    chk("t2_tag_after_wrap", rif.out_alloc_tag, 2);
    for (int t = 2; t <= DEPTH; t++) begin
      expect_commit(t, t, t * 3);
      lsb_wr(t, t * 3);
    end
    expect_commit(20, 1, 32'h777);
    alu_wr(1, 32'h777, 1'b0, 0);
    repeat (6) tick();
    chk("t2_drained", sb_q.size(), 0);
    chk("t2_empty_full", rif.out_full, 0);

    // Operand query with CDB forwarding (tags 2 and 3)
    alloc(11, 1'b0, 1'b0);
    alloc(12, 1'b0, 1'b0);
    rif.in_alu_valid = 1'b1;
    rif.in_alu_tag = rob_tag_t'(3);
    rif.in_alu_value = data_t'(32'h55);
    rif.in_query_tag1 = rob_tag_t'(3);
    rif.in_query_tag2 = rob_tag_t'(2);
    #1;
    chk("t3_fwd_ready", rif.out_query_ready1, 1);
    chk("t3_fwd_value", rif.out_query_value1, 32'h55);
    chk("t3_pending_ready", rif.out_query_ready2, 0);
    tick();
    rif.in_alu_valid = 1'b0;
    rif.in_query_tag1 = ZERO_TAG_ROB;
    rif.in_query_tag2 = rob_tag_t'(3);
    #1;
    chk("t3_zero_ready", rif.out_query_ready1, 1);
    chk("t3_zero_value", rif.out_query_value1, 0);
    chk("t3_stored_ready", rif.out_query_ready2, 1);
    chk("t3_stored_value", rif.out_query_value2, 32'h55);
    rif.in_lsb_valid = 1'b1;
    rif.in_lsb_tag = rob_tag_t'(2);
    rif.in_lsb_value = data_t'(32'h22);
    rif.in_query_tag2 = rob_tag_t'(2);
    #1;
    chk("t3_lsb_fwd_ready", rif.out_query_ready2, 1);
    chk("t3_lsb_fwd_value", rif.out_query_value2, 32'h22);
    expect_commit(11, 2, 32'h22);
    expect_commit(12, 3, 32'h55);
    tick();
    rif.in_lsb_valid = 1'b0;
    repeat (4) tick();
    chk("t3_drained", sb_q.size(), 0);

    // Misprediction at the head flushes younger entries
    do_reset();
    alloc(0, 1'b1, 1'b0);
    alloc(5, 1'b0, 1'b0);
    alloc(6, 1'b0, 1'b0);
    alloc(7, 1'b0, 1'b0);
    expect_commit(0, 1, 32'h104);
    mis_exp_q.push_back(data_t'(32'h100));
    rif.in_lsb_valid = 1'b1;
    rif.in_lsb_tag = rob_tag_t'(3);
    rif.in_lsb_value = data_t'(32'h33);
    alu_wr(1, 32'h104, 1'b1, 32'h100);
    rif.in_lsb_valid = 1'b0;
    for (int k = 0; k < 10 && !rif.out_misbranch; k++) tick();
    chk("t4_misbranch", rif.out_misbranch, 1);
    chk("t4_pc", rif.out_misbranch_pc, 32'h100);
    chk("t4_flush_full", rif.out_full, 0);
    chk("t4_flush_tag", rif.out_alloc_tag, 1);
    rif.in_fetcher_ce = 1'b1;
    rif.in_alloc_dest_reg = reg_tag_t'(9);
    rif.in_alu_valid = 1'b1;
    rif.in_alu_tag = rob_tag_t'(2);
    rif.in_alu_value = data_t'(1);
    tick();
    rif.in_fetcher_ce = 1'b0;
    rif.in_alu_valid = 1'b0;
    chk("t4_stale_alloc", rif.out_alloc_tag, 1);
    chk("t4_pulse_end", rif.out_misbranch, 0);
    repeat (6) tick();
    chk("t4_mis_count", mis_seen, 1);
    chk("t4_sb_empty", sb_q.size(), 0);

    // rdy low freezes a ready head
    do_reset();
    alloc(3, 1'b0, 1'b0);
    alu_wr(1, 32'h99, 1'b0, 0);
    rif.rdy = 1'b0;
    rif.in_fetcher_ce = 1'b1;
    rif.in_alloc_dest_reg = reg_tag_t'(4);
    repeat (3) tick();
    rif.in_fetcher_ce = 1'b0;
    chk("t5_hold_tag", rif.out_alloc_tag, 2);
    chk("t5_no_commit", rif.out_commit_rob, 0);
    rif.rdy = 1'b1;
    expect_commit(3, 1, 32'h99);
    tick();
    chk("t5_commit_after_rdy", rif.out_commit_rob, 1);
    repeat (4) tick();
    chk("t5_once", commit_cyc.size(), 1);

    // Reset with live entries
    do_reset();
    for (int i = 0; i < 5; i++) alloc(i + 1, 1'b0, 1'b0);
    chk("t6_live_tag", rif.out_alloc_tag, 6);
    rst = 1'b1;
    rif.in_alu_valid = 1'b1;
    rif.in_alu_tag = rob_tag_t'(1);
    rif.in_alu_value = data_t'(32'hAB);
    tick();
    rif.in_alu_valid = 1'b0;
    rst = 1'b0;
    rif.in_query_tag1 = rob_tag_t'(1);
    #1;
    chk("t6_full", rif.out_full, 0);
    chk("t6_alloc_tag", rif.out_alloc_tag, 1);
    chk("t6_commit_rob", rif.out_commit_rob, 0);
    chk("t6_query_cleared", rif.out_query_ready1, 0);
    repeat (4) tick();

    chk("end_sb_empty", sb_q.size(), 0);
    chk("end_mis_empty", mis_exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
